ifetch: RTL and testbench
=========================

Name: ifetch

Overview:
Instruction-fetch stage for the single-issue MIPS core, directly upstream of the instruction ROM. Owns the PC and drives the ROM word address. Captures the ROM's combinational instruction word into an IF/ID pipeline register for the decoder. Supports stall, branch/jump redirect with flush, external halt (syscall exit), and a fault stop on an out-of-range or misaligned PC.

Parameters:
ADRS_W, 9, ROM word-address width; ROM covers byte addresses 0 to 2^(ADRS_W+2)-1.
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
rom_adrs  output  ADRS_W  ROM word address, combinational = pc[ADRS_W+1:2].
rom_dout  input  32  ROM instruction word, valid in the same cycle as rom_adrs.
stall  input  1  hold PC and IF/ID (hazard from decode/execute).
redirect  input  1  load redirect_pc (taken branch/jump) and flush IF/ID.
redirect_pc  input  32  redirect target byte address.
halt  input  1  stop fetching (syscall exit), sticky until reset.
if_valid  output  1  IF/ID holds a real instruction.
if_inst  output  32  IF/ID instruction word.
if_pc  output  32  byte address of if_inst.
if_pc4  output  32  if_pc + 4.
halted  output  1  fetch is in HALT.
fault  output  1  fetch is in FAULT.

Behaviour:
- States: RUN, HALT, FAULT. Reset -> RUN. HALT and FAULT exit only by rst.
- Reset (synchronous; wins over everything): pc=RESET_PC, if_valid=0, if_inst=0, if_pc=0, if_pc4=0, state RUN, halted=0, fault=0.
- rom_adrs is purely combinational from the pc register; ROM data is captured on the same edge that advances pc. IF latency is 1 cycle: the instruction at pc appears on if_inst in the cycle after pc is presented.
- Priority per edge in RUN: halt > redirect > fault check > stall > normal.
- Normal: if_inst<=rom_dout, if_pc<=pc, if_pc4<=pc+4, if_valid<=1, pc<=pc+4 (32-bit add, modulo 2^32).
- Stall: pc and all IF/ID registers hold. if_valid is not cleared.
- Redirect (with or without stall): pc<=redirect_pc, if_valid<=0, other IF/ID fields hold. Redirect overrides stall.
- Halt: state<=HALT, if_valid<=0, pc holds. halt while redirect is asserted still halts; redirect is ignored.
- Fault check, on the current pc in RUN with no halt and no redirect:
  - Condition: pc[1:0]!=0, or pc bits above ADRS_W+1 nonzero.
  - Result: state<=FAULT, if_valid<=0, pc holds. No wrap-around into the ROM is permitted.
  - The check also applies while stall is asserted.
- In HALT/FAULT: all inputs ignored, all registers hold, if_valid=0.
- halted = (state==HALT); fault = (state==FAULT); both registered.

Decomposition:
- Shared package/header mips_defs: RESET_PC default, state encodings (RUN=2'd0, HALT=2'd1, FAULT=2'd2), and the SYSCALL opcode constant 32'h0000000c for the bench and decoder.
- Single module; no sub-module needed. The existing rom is instantiated beside it at top level, not inside.

Test Plan:
- Reset then run with ROM = {0:20110002, 1:20120003, 2:72324002, 3:2402000a, 4:0000000c} -> rom_adrs 0,1,2,3,4 on successive cycles; if_inst 20110002 with if_pc=0/if_pc4=4 on cycle 1, then 20120003 (pc 4), 72324002 (pc 8).
- stall high for 3 cycles while if_inst=20120003 -> pc=8, if_inst, if_pc=4 and if_valid=1 all frozen; resumes with 72324002 the cycle after stall drops.
- redirect=1, redirect_pc=0x0C, with stall=1 at the same edge -> next cycle if_valid=0, rom_adrs=3; following cycle if_inst=2402000a, if_pc=0x0C.
- halt asserted when pc=0x10 -> halted=1 next cycle, if_valid=0, pc stays 0x10; later redirect and halt pulses have no effect; rst returns to pc=0, RUN.
- redirect_pc=0x06 (misaligned) -> after load, next edge fault=1, if_valid=0; likewise run sequentially from pc=0x7FC -> pc=0x800 then fault=1, and rom_adrs never wraps to 0 with valid=1.
- rst asserted mid-run while stall=1 and redirect=1 -> next cycle pc=0, if_valid=0, if_inst=0, state RUN.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// ============================================================================
// Module      : mips_defs
// Description : Shared MIPS core definitions: reset PC, fetch-state encodings,
//               SYSCALL instruction word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_defs;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] SYSCALL          = 32'h0000_000c;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

endpackage : mips_defs

`default_nettype wire

// File: rtl/ifetch.sv
// ============================================================================
// Module      : ifetch
// Description : Instruction-fetch stage: owns the PC, addresses the ROM and
//               registers the fetched word into IF/ID.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch
    import mips_defs::*;
#(
    parameter int          ADRS_W   = 9,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADRS_W-1:0] rom_adrs,
    input  logic [31:0]       rom_dout,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    input  logic              halt,
    output logic              if_valid,
    output logic [31:0]       if_inst,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_pc4,
    output logic              halted,
    output logic              fault
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic         w_misaligned;
    logic         w_out_of_range;
    logic         w_bad_pc;

    assign rom_adrs = r_pc[ADRS_W+1:2];

    // Any address bit above the ROM window is a fault; the PC never wraps back in.
    assign w_misaligned   = (r_pc[1:0] != 2'b00);
    assign w_out_of_range = ((r_pc >> (ADRS_W + 2)) != 32'd0);
    assign w_bad_pc       = w_misaligned | w_out_of_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_pc     <= RESET_PC;
            if_valid <= 1'b0;
            if_inst  <= 32'd0;
            if_pc    <= 32'd0;
            if_pc4   <= 32'd0;
            halted   <= 1'b0;
            fault    <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (halt) begin
                        r_state  <= ST_HALT;
                        halted   <= 1'b1;
                        if_valid <= 1'b0;
                    end else if (redirect) begin
                        r_pc     <= redirect_pc;
                        if_valid <= 1'b0;
                    end else if (w_bad_pc) begin
                        r_state  <= ST_FAULT;
                        fault    <= 1'b1;
                        if_valid <= 1'b0;
                    end else if (!stall) begin
                        if_inst  <= rom_dout;
                        if_pc    <= r_pc;
                        if_pc4   <= r_pc + 32'd4;
                        if_valid <= 1'b1;
                        r_pc     <= r_pc + 32'd4;
                    end
                end
                default: begin
                    if_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : ifetch

`default_nettype wire

// File: tb/tb_ifetch.sv
// ============================================================================
// Module      : tb_ifetch
// Description : Self-checking bench for ifetch against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifetch;
    import mips_defs::*;

    localparam int          c_adrs_w    = 9;
    localparam int          c_rom_words = 1 << c_adrs_w;
    localparam logic [31:0] c_rom_bytes = 32'(c_rom_words * 4);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [c_adrs_w-1:0] rom_adrs;
    logic [31:0]         rom_dout;
    logic                stall = 1'b0;
    logic                redirect = 1'b0;
    logic [31:0]         redirect_pc = 32'd0;
    logic                halt = 1'b0;
    logic                if_valid;
    logic [31:0]         if_inst;
    logic [31:0]         if_pc;
    logic [31:0]         if_pc4;
    logic                halted;
    logic                fault;

    logic [31:0] rom [c_rom_words];
    assign rom_dout = rom[rom_adrs];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_halted, m_fault, m_valid;
    logic [31:0] m_inst, m_ipc, m_ipc4;

    ifetch #(.ADRS_W(c_adrs_w), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .rom_adrs(rom_adrs), .rom_dout(rom_dout),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .if_pc4(if_pc4), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("rom_adrs", 32'(rom_adrs), (m_pc / 4) % c_rom_words);
        chk("if_valid", 32'(if_valid), 32'(m_valid));
        chk("if_inst",  if_inst, m_inst);
        chk("if_pc",    if_pc,   m_ipc);
        chk("if_pc4",   if_pc4,  m_ipc4);
        chk("halted",   32'(halted), 32'(m_halted));
        chk("fault",    32'(fault),  32'(m_fault));
    endtask

    // Model one clock edge from the rules, then sample DUT on the falling edge.
    task automatic cyc(input bit r, input bit s, input bit rd, input logic [31:0] rpc, input bit h);
        rst = r; stall = s; redirect = rd; redirect_pc = rpc; halt = h;
        @(posedge clk);
        if (r) begin
            m_pc = 32'h0; m_halted = 0; m_fault = 0; m_valid = 0;
            m_inst = 0; m_ipc = 0; m_ipc4 = 0;
        end else if (!m_halted && !m_fault) begin
            if (h) begin
                m_halted = 1; m_valid = 0;
            end else if (rd) begin
                m_pc = rpc; m_valid = 0;
            end else if ((m_pc % 4) != 0 || m_pc >= c_rom_bytes) begin
                m_fault = 1; m_valid = 0;
            end else if (!s) begin
                m_inst = rom[m_pc / 4];
                m_ipc  = m_pc;
                m_ipc4 = m_pc + 4;
                m_valid = 1;
                m_pc   = m_pc + 4;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        for (int i = 0; i < c_rom_words; i++) rom[i] = $urandom;
        rom[0] = 32'h20110002; rom[1] = 32'h20120003; rom[2] = 32'h72324002;
        rom[3] = 32'h2402000a; rom[4] = SYSCALL;

        @(negedge clk);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("reset_inst", if_inst, 32'h0);

        // Sequential program run
        cyc(0, 0, 0, 0, 0);
        chk("prog_inst0", if_inst, 32'h20110002);
        chk("prog_pc4_0", if_pc4, 32'h4);
        cyc(0, 0, 0, 0, 0);
        chk("prog_inst1", if_inst, 32'h20120003);
        // Stall 3 cycles then resume
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("stall_pc", if_pc, 32'h4);
        cyc(0, 0, 0, 0, 0);
        chk("resume_inst", if_inst, 32'h72324002);
        // Redirect overriding stall
        cyc(0, 1, 1, 32'h0C, 0);
        chk("redir_adrs", 32'(rom_adrs), 32'd3);
        cyc(0, 0, 0, 0, 0);
        chk("redir_inst", if_inst, 32'h2402000a);
        // Halt at pc 0x10, then ignored pulses
        cyc(0, 0, 1, 32'h20, 1);
        chk("halted", 32'(halted), 32'd1);
        cyc(0, 0, 1, 32'h20, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("halt_adrs", 32'(rom_adrs), 32'd4);
        cyc(1, 0, 0, 0, 0);
        // Misaligned redirect
        cyc(0, 0, 1, 32'h06, 0);
        cyc(0, 0, 0, 0, 0);
        chk("misalign_fault", 32'(fault), 32'd1);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        // Run off the end of the ROM
        cyc(0, 0, 1, 32'h7FC, 0);
        cyc(0, 0, 0, 0, 0);
        chk("last_pc", if_pc, 32'h7FC);
        cyc(0, 0, 0, 0, 0);
        chk("oob_fault", 32'(fault), 32'd1);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        // Reset mid-run with stall and redirect asserted
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 1, 32'h40, 0);
        chk("rst_mid_valid", 32'(if_valid), 32'd0);

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rpc;
            int sel;
            sel = int'($urandom_range(0, 7));
            if (sel == 0)      rpc = {21'd0, 9'($urandom), 2'($urandom_range(1, 3))};
            else if (sel == 1) rpc = $urandom | 32'h800;
            else               rpc = {21'd0, 9'($urandom), 2'b00};
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 7) == 0, rpc, $urandom_range(0, 59) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ifetch

`default_nettype wire
